// File: rtl/key_step_pkg.sv
// Shared types and sizing helpers for the push-button step controller.
package key_step_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } step_state_t;

  // Width of the shared debounce/repeat counter: $clog2(max(debounce, rpt) + 1).
  function automatic int unsigned cnt_width(input int unsigned debounce,
                                            input int unsigned rpt);
    int unsigned m;
    m = (debounce > rpt) ? debounce : rpt;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_step_ctrl.sv
// Debounced push-button step controller: single step, auto-repeat or free-run
// enable for the pipeline registers, plus a count of issued steps.
module key_step_ctrl
  import key_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_CYCLES   = 0,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_n,
  input  logic             run_sw,
  output logic             step_en,
  output logic             pressed,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] RPT_LAST = DW'(REPEAT_CYCLES - 1);
  localparam bit RPT_EN = (REPEAT_CYCLES != 0);

  logic key_s;
  logic run_s;

  step_state_t state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
  logic pulse;

  // Key idles released (high); run switch idles off.
  sync2 #(.RST_VAL(1'b1)) u_sync_key (
    .clk   (clk),
    .reset (reset),
    .d     (key_n),
    .q     (key_s)
  );

  sync2 #(.RST_VAL(1'b0)) u_sync_run (
    .clk   (clk),
    .reset (reset),
    .d     (run_sw),
    .q     (run_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The entering IDLE sample counts as the first stable one, so a wait state
  // completes once the incremented count reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse   = 1'b0;
    cnt_inc = cnt_q + DW'(1);
    unique case (state_q)
      IDLE: begin
        if (!key_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
        end else if (cnt_inc == DEB_LAST) begin
          state_d = HELD;
          pulse   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
        end else if (RPT_EN) begin
          if (cnt_q == RPT_LAST) begin
            pulse = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = HELD;
        end else if (cnt_inc == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Registered outputs; run mode absorbs FSM pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_en    <= 1'b0;
      pressed    <= 1'b0;
      step_count <= '0;
    end else begin
      step_en <= run_s | pulse;
      pressed <= (state_d == HELD) || (state_d == RELEASE_WAIT);
      if (step_en) step_count <= step_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_key_step_ctrl.sv
// Directed bench for key_step_ctrl: one instance without repeat (32-bit count),
// one with auto-repeat and a 4-bit count.
module tb_key_step_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic key_n;
  logic run_sw;
  logic sel;

  logic key_a, run_a, key_b, run_b;
  logic step_en_a, pressed_a, step_en_b, pressed_b;
  logic [31:0] count_a;
  logic [3:0]  count_b;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  bit bnc_pat [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  assign key_a = sel ? 1'b1  : key_n;
  assign run_a = sel ? 1'b0  : run_sw;
  assign key_b = sel ? key_n : 1'b1;
  assign run_b = sel ? run_sw : 1'b0;

  always #5 clk = ~clk;

  key_step_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0), .CNT_W(32)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_a),
    .run_sw     (run_a),
    .step_en    (step_en_a),
    .pressed    (pressed_a),
    .step_count (count_a)
  );

  key_step_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8), .CNT_W(4)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_b),
    .run_sw     (run_b),
    .step_en    (step_en_b),
    .pressed    (pressed_b),
    .step_count (count_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit past the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int npulse;
    int nrel;
    int gaps;

    reset  = 1'b0;
    key_n  = 1'b1;
    run_sw = 1'b0;
    sel    = 1'b0;
    tick(3);
    check("rst_step_en_a", 32'(step_en_a), 32'd0);
    check("rst_pressed_a", 32'(pressed_a), 32'd0);
    check("rst_count_a",   count_a,        32'd0);
    check("rst_count_b",   32'(count_b),   32'd0);
    reset = 1'b1;
    tick(2);

    // Clean press: one pulse in the cycle after edge 5.
    key_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check($sformatf("a_press_k%0d", k), 32'(step_en_a), 32'(k == 5));
    end
    check("a_press_pressed", 32'(pressed_a), 32'd1);
    check("a_press_count",   count_a,        32'd1);

    // Release bounce of two samples: stays held, no pulse.
    npulse = 0;
    nrel   = 0;
    key_n  = 1'b1;
    for (int k = 0; k < 14; k++) begin
      if (k == 2) key_n = 1'b0;
      tick(1);
      npulse += int'(step_en_a);
      nrel   += int'(!pressed_a);
    end
    check("a_relbnc_pulses",  32'(npulse), 32'd0);
    check("a_relbnc_dropped", 32'(nrel),   32'd0);

    // Clean release: pressed falls after edge 5.
    key_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check($sformatf("a_release_k%0d", k), 32'(pressed_a), 32'(k < 5));
    end
    check("a_release_count", count_a, 32'd1);

    // Press bounce shorter than the debounce window.
    npulse = 0;
    nrel   = 0;
    for (int k = 0; k < 19; k++) begin
      key_n = (k < 7) ? bnc_pat[k] : 1'b1;
      tick(1);
      npulse += int'(step_en_a);
      nrel   += int'(pressed_a);
    end
    check("a_bounce_pulses",  32'(npulse), 32'd0);
    check("a_bounce_pressed", 32'(nrel),   32'd0);
    check("a_bounce_count",   count_a,     32'd1);

    // Run mode for 100 cycles with a press absorbed in the middle.
    gaps   = 0;
    run_sw = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k == 20) key_n = 1'b0;
      if (k == 40) key_n = 1'b1;
      tick(1);
      if (k == 1) check("a_run_lat_edge1", 32'(step_en_a), 32'd0);
      if (k == 2) check("a_run_lat_edge2", 32'(step_en_a), 32'd1);
      if (k >= 2) gaps += int'(!step_en_a);
    end
    check("a_run_gaps", 32'(gaps), 32'd0);
    run_sw = 1'b0;
    tick(3);
    check("a_run_off", 32'(step_en_a), 32'd0);
    tick(5);
    check("a_run_count",   count_a,        32'd101);
    check("a_run_pressed", 32'(pressed_a), 32'd0);

    // Auto-repeat on instance b: press pulse then one every 8 cycles.
    sel   = 1'b1;
    tick(2);
    key_n = 1'b0;
    for (int k = 0; k < 47; k++) begin
      tick(1);
      check($sformatf("b_rpt_k%0d", k), 32'(step_en_b),
            32'((k >= 5) && ((k - 5) % 8 == 0)));
    end
    key_n = 1'b1;
    tick(12);
    check("b_rpt_count",   32'(count_b),   32'd6);
    check("b_rpt_pressed", 32'(pressed_b), 32'd0);

    // Eleven run cycles bring the 4-bit count to 17, wrapping to 1.
    run_sw = 1'b1;
    tick(11);
    run_sw = 1'b0;
    tick(5);
    check("b_wrap_count", 32'(count_b), 32'd1);

    // Reset in the middle of PRESS_WAIT with the key held.
    key_n = 1'b0;
    tick(3);
    reset = 1'b0;
    #1;
    check("b_midrst_count",   32'(count_b),   32'd0);
    check("b_midrst_step_en", 32'(step_en_b), 32'd0);
    check("b_midrst_pressed", 32'(pressed_b), 32'd0);
    tick(2);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check($sformatf("b_rerst_k%0d", k), 32'(step_en_b), 32'(k == 5));
    end
    check("b_rerst_count", 32'(count_b), 32'd1);
    key_n = 1'b1;
    tick(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/key_step_ctrl.md
# key_step_ctrl

Push-button step controller for the FPGA build of the pipelined RV32I core. It synchronizes and debounces a raw active-low KEY and produces the clean, clock-synchronous `step_en` that drives the enable of every enabled pipeline register: one pulse per press, optional auto-repeat while held, or a continuous enable in run mode. It also keeps a count of issued steps for display on the board.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples required to accept a level change (20 ms at 50 MHz); minimum 2.
- `REPEAT_CYCLES`, default 0: auto-repeat period while the key is held; 0 disables auto-repeat.
- `CNT_W`, default 32: width of `step_count`.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  reset, asynchronous, active-low.
- `key_n`  input  1  raw push button, active-low, asynchronous, bouncing.
- `run_sw`  input  1  raw slide switch, asynchronous; 1 selects free-run.
- `step_en`  output  1  enable to the pipeline registers.
- `pressed`  output  1  debounced key level, 1 while pressed.
- `step_count`  output  CNT_W  number of cycles in which `step_en` was 1.

## Operation
- `key_n` and `run_sw` each pass through a 2-flop synchronizer: `key_s` and `run_s`. Synchronizer flops reset to released/0.
- One debounce counter, width `$clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1)`, is shared by all states. It clears on every state transition.
- FSM states and transitions:
  - IDLE: if `key_s`=0, go to PRESS_WAIT.
  - PRESS_WAIT: counts cycles while `key_s`=0. If `key_s`=1, return to IDLE (bounce rejected, no pulse). When the count reaches DEBOUNCE_CYCLES-1 with `key_s`=0, go to HELD and issue a step pulse.
  - HELD: `pressed`=1. If `key_s`=1, go to RELEASE_WAIT. If REPEAT_CYCLES≠0, count; at REPEAT_CYCLES-1, issue a step pulse and clear the counter.
  - RELEASE_WAIT: counts cycles while `key_s`=1. If `key_s`=0, return to HELD with no pulse and the repeat counter cleared. When the count reaches DEBOUNCE_CYCLES-1, go to IDLE.
- `pressed` is 1 in HELD and RELEASE_WAIT.
- Step pulse: `step_en` is registered and high for exactly one clk cycle.
- Run mode: when `run_s`=1, `step_en`=1 every cycle. The FSM keeps tracking the key, and its pulses are absorbed (OR). When `run_s` falls, `step_en` returns to pulse behaviour on the next cycle.
- `step_count` increments on each rising edge at which `step_en`=1. It wraps from 2^CNT_W-1 to 0 with no flag.
- Reset values: `step_en`=0, `pressed`=0, `step_count`=0, state IDLE, counter 0.
- Reset mid-operation clears everything immediately. A key still held at reset release is re-debounced and yields one pulse.

## Timing
- Press latency: with `key_n` held low from before rising edge 0, `key_s`=0 after edge 1. `step_en`=1 for the cycle following edge DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges after the press.
- Run-mode latency: `step_en` follows `run_sw` after 3 rising edges.
- `step_en` is stable from rising edge to rising edge, so falling-edge-clocked pipeline registers see half a period of setup margin.
- Auto-repeat: pulses are spaced exactly REPEAT_CYCLES cycles apart, the first one REPEAT_CYCLES cycles after the press pulse.
- Bounce shorter than DEBOUNCE_CYCLES samples in either wait state produces no pulse and no `pressed` change.

## Structure
- Package `key_step_pkg`: state enum typedef `step_state_t` {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} and the counter-width function.
- Sub-module `sync2` (parameterizable reset value), instantiated twice.
- One FSM, one shared counter, the output register and the step counter live in `key_step_ctrl`.

## Test plan
- DEBOUNCE_CYCLES=4, REPEAT_CYCLES=0. Assert reset, release it, hold `key_n`=0 → `step_en` high for exactly one cycle 6 edges after the press; `pressed`=1; `step_count`=1.
- Bounce: `key_n` low 3 cycles, high 1, low 3, high → no pulse, `pressed` stays 0, `step_count`=0.
- Release bounce: after an accepted press, `key_n` high 2 cycles then low → back to HELD, no second pulse. A later clean release → IDLE after 4+2 edges, `pressed`=0.
- REPEAT_CYCLES=8. Hold the key 40 cycles after the first pulse → pulses 8 cycles apart, 5 repeats, `step_count`=6.
- `run_sw`=1 for 100 cycles → `step_en` high continuously from edge 3, `step_count`=100. A press during run mode adds no extra count.
- CNT_W=4, 17 steps → `step_count`=1 (wrap). Assert reset mid-PRESS_WAIT with the key held → outputs 0 immediately, then one pulse 6 edges after reset release.
